dmem_port_arbiter: RTL



---
 rtl/dmem_port_arbiter_if.sv | 51 +++++
 rtl/dmem_port_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Data-memory port arbiter bundle: load request/response, store-buffer drain,
// memory request/response and the ROB flush pulse.
interface dmem_port_arbiter_if #(
  parameter int unsigned WORD_SIZE_P = 16,
  parameter int unsigned ROB_TAG_W   = 4
);
  logic                   rob_mispredict_i;
  logic                   ld_v_i;
  logic [WORD_SIZE_P-1:0] ld_addr_i;
  logic [ROB_TAG_W-1:0]   ld_tag_i;
  logic                   ld_ready_o;
  logic                   ld_resp_v_o;
  logic [WORD_SIZE_P-1:0] ld_resp_data_o;
  logic [ROB_TAG_W-1:0]   ld_resp_tag_o;
  logic                   sb_mem_v_i;
  logic [WORD_SIZE_P-1:0] sb_mem_addr_i;
  logic [WORD_SIZE_P-1:0] sb_mem_data_i;
  logic                   sb_mem_ready_o;
  logic                   mem_v_o;
  logic                   mem_we_o;
  logic [WORD_SIZE_P-1:0] mem_addr_o;
  logic [WORD_SIZE_P-1:0] mem_data_o;
  logic                   mem_ready_i;
  logic                   mem_resp_v_i;
  logic [WORD_SIZE_P-1:0] mem_resp_data_i;
  logic                   busy_o;

  // Arbiter side: it masters the memory port on behalf of both requesters.
  modport master (
    input  rob_mispredict_i,
    input  ld_v_i, ld_addr_i, ld_tag_i,
    output ld_ready_o, ld_resp_v_o, ld_resp_data_o, ld_resp_tag_o,
    input  sb_mem_v_i, sb_mem_addr_i, sb_mem_data_i,
    output sb_mem_ready_o,
    output mem_v_o, mem_we_o, mem_addr_o, mem_data_o,
    input  mem_ready_i, mem_resp_v_i, mem_resp_data_i,
    output busy_o
  );

  // Environment side: execute, store buffer and memory.
  modport slave (
    output rob_mispredict_i,
    output ld_v_i, ld_addr_i, ld_tag_i,
    input  ld_ready_o, ld_resp_v_o, ld_resp_data_o, ld_resp_tag_o,
    output sb_mem_v_i, sb_mem_addr_i, sb_mem_data_i,
    input  sb_mem_ready_o,
    input  mem_v_o, mem_we_o, mem_addr_o, mem_data_o,
    output mem_ready_i, mem_resp_v_i, mem_resp_data_i,
    input  busy_o
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between execute loads and store-buffer drains.
// One transaction outstanding; loads win unless a waiting store has been
// passed over STARVE_LIMIT times. Load responses can be squashed by the ROB.
module dmem_port_arbiter #(
  parameter int unsigned WORD_SIZE_P  = 16,
  parameter int unsigned ROB_TAG_W    = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  dmem_port_arbiter_if.master bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, LD_WAIT, ST_WAIT} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     starve_q, starve_d;
  logic                 squash_q, squash_d;
  logic [ROB_TAG_W-1:0] tag_q, tag_d;

  logic force_st, ld_gnt, st_gnt;

  // Grant, memory request mux, response path and next-state computation.
  // Grants are qualified by reset_n_i so every output reads 0 while in reset.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    squash_d = squash_q;
    tag_d    = tag_q;

    force_st = 1'b0;
    ld_gnt   = 1'b0;
    st_gnt   = 1'b0;

    bus.ld_ready_o     = 1'b0;
    bus.sb_mem_ready_o = 1'b0;
    bus.mem_v_o        = 1'b0;
    bus.mem_we_o       = 1'b0;
    bus.mem_addr_o     = '0;
    bus.mem_data_o     = '0;
    bus.ld_resp_v_o    = 1'b0;
    bus.ld_resp_data_o = '0;
    bus.ld_resp_tag_o  = '0;
    bus.busy_o         = 1'b0;

    unique case (state_q)
      IDLE: begin
        force_st = bus.sb_mem_v_i && (starve_q == STARVE_MAX);
        ld_gnt   = reset_n_i && bus.ld_v_i && !bus.rob_mispredict_i && !force_st;
        st_gnt   = reset_n_i && !ld_gnt && bus.sb_mem_v_i;

        bus.mem_v_o = ld_gnt || st_gnt;
        if (ld_gnt) begin
          bus.mem_addr_o = bus.ld_addr_i;
        end else if (st_gnt) begin
          bus.mem_we_o   = 1'b1;
          bus.mem_addr_o = bus.sb_mem_addr_i;
          bus.mem_data_o = bus.sb_mem_data_i;
        end

        bus.ld_ready_o     = ld_gnt && bus.mem_ready_i;
        bus.sb_mem_ready_o = st_gnt && bus.mem_ready_i;

        // Counter: no waiting store clears it; an accepted store clears it;
        // an accepted load while a store waits bumps it (saturating).
        if (!bus.sb_mem_v_i) begin
          starve_d = '0;
        end else if (bus.sb_mem_ready_o) begin
          starve_d = '0;
        end else if (bus.ld_ready_o && starve_q != STARVE_MAX) begin
          starve_d = starve_q + 1'b1;
        end

        if (bus.ld_ready_o) begin
          tag_d   = bus.ld_tag_i;
          state_d = LD_WAIT;
        end else if (bus.sb_mem_ready_o) begin
          state_d = ST_WAIT;
        end
      end

      LD_WAIT: begin
        bus.busy_o        = 1'b1;
        bus.ld_resp_tag_o = tag_q;
        if (bus.rob_mispredict_i) begin
          squash_d = 1'b1;
        end
        if (bus.mem_resp_v_i) begin
          bus.ld_resp_v_o    = !squash_q && !bus.rob_mispredict_i;
          bus.ld_resp_data_o = bus.mem_resp_data_i;
          squash_d           = 1'b0;
          state_d            = IDLE;
        end
      end

      ST_WAIT: begin
        bus.busy_o = 1'b1;
        if (bus.mem_resp_v_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, starvation counter, squash flag and captured load tag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      starve_q <= '0;
      squash_q <= 1'b0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      squash_q <= squash_d;
      tag_q    <= tag_d;
    end
  end

endmodule
